debug_info_feeder: RTL and testbench

- Producer side of the visuMon debug-LED write interface.
- Watches a vector of per-LED status bits and colour codes coming from the GM64 core.
- Detects any change and writes only the changed LEDs into visuMon through the active-low chip-select / debugInfo_t port.
- Sits between the core's debug taps and visuMon; both blocks run on the 25 MHz pixel clock.

---
 rtl/debug_info_feeder_pkg.sv | 23 ++
 rtl/debug_info_feeder_shadow.sv | 53 +++++
 rtl/debug_info_feeder.sv | 100 ++++++++++
 tb/tb_debug_info_feeder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_info_feeder_pkg.sv
// Shared GM64 debug types: visuMon write payload and the feeder FSM states.
// Imported by the LED feeder and its shadow store.
package debug_info_feeder_pkg;

  localparam int LED_NO_W = 8;

  typedef struct packed {
    logic [LED_NO_W-1:0] ledNo;
    logic [3:0]          color;
    logic                status;
  } debugInfo_t;

  typedef enum logic [1:0] {
    SCAN,
    SEND,
    GAP
  } feeder_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_info_feeder_shadow.sv
// Last-written copy of every LED plus a valid bit.
// Flags each LED whose live inputs differ from what visuMon holds.
module debug_led_shadow
  import debug_info_feeder_pkg::*;
#(
  parameter int NUM_LEDS = 32,
  localparam int IW = idx_width(NUM_LEDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_LEDS-1:0]      status_i,
  input  logic [NUM_LEDS-1:0][3:0] color_i,
  input  logic                     wr_en_i,
  input  logic [IW-1:0]            wr_idx_i,
  input  logic                     wr_status_i,
  input  logic [3:0]               wr_color_i,
  input  logic                     clr_i,
  output logic [NUM_LEDS-1:0]      mismatch_o
);

  logic [NUM_LEDS-1:0]      valid_q;
  logic [NUM_LEDS-1:0]      status_q;
  logic [NUM_LEDS-1:0][3:0] color_q;

  // Clear-all beats a write landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      status_q <= '0;
      color_q  <= '0;
    end else begin
      if (clr_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_idx_i] <= 1'b1;
      end
      if (wr_en_i) begin
        status_q[wr_idx_i] <= wr_status_i;
        color_q[wr_idx_i]  <= wr_color_i;
      end
    end
  end

  always_comb begin
    mismatch_o = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      mismatch_o[k] = !valid_q[k]
                   || (status_i[k] != status_q[k])
                   || (color_i[k] != color_q[k]);
    end
  end

endmodule

// File: rtl/debug_info_feeder.sv
// Scans GM64 debug taps and writes changed LEDs into visuMon
// through the active-low chip-select / debugInfo_t port.
module debug_info_feeder
  import debug_info_feeder_pkg::*;
#(
  parameter int NUM_LEDS   = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     i_clk25Mhz,
  input  logic                     i_reset,
  input  logic [NUM_LEDS-1:0]      i_status,
  input  logic [NUM_LEDS-1:0][3:0] i_color,
  input  logic                     i_refresh,
  output logic                     o_cs,
  output debugInfo_t               o_debugInfo,
  output logic                     o_busy
);

  localparam int IW = idx_width(NUM_LEDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  feeder_state_e       state_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic [3:0]          gap_q;
  logic                refresh_q;
  logic [NUM_LEDS-1:0] mismatch;
  logic                sh_wr;
  logic                sh_clr;

  assign idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign sh_wr  = (state_q == SEND);
  assign sh_clr = (state_q == SCAN) && refresh_q;
  assign o_busy = (state_q != SCAN) || refresh_q || (|mismatch);

  debug_led_shadow #(
    .NUM_LEDS (NUM_LEDS)
  ) u_shadow (
    .clk_i       (i_clk25Mhz),
    .rst_ni      (i_reset),
    .status_i    (i_status),
    .color_i     (i_color),
    .wr_en_i     (sh_wr),
    .wr_idx_i    (idx_q),
    .wr_status_i (o_debugInfo.status),
    .wr_color_i  (o_debugInfo.color),
    .clr_i       (sh_clr),
    .mismatch_o  (mismatch)
  );

  always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= SCAN;
      idx_q       <= '0;
      gap_q       <= '0;
      refresh_q   <= 1'b0;
      o_cs        <= 1'b1;
      o_debugInfo <= '0;
    end else begin
      // A new pulse in the clearing cycle stays pending.
      if (sh_clr) refresh_q <= 1'b0;
      if (i_refresh) refresh_q <= 1'b1;
      unique case (state_q)
        SCAN: begin
          if (mismatch[idx_q]) begin
            state_q            <= SEND;
            o_cs               <= 1'b0;
            o_debugInfo.ledNo  <= LED_NO_W'(idx_q) + 1'b1;
            o_debugInfo.color  <= i_color[idx_q];
            o_debugInfo.status <= i_status[idx_q];
          end else begin
            idx_q <= idx_d;
          end
        end
        SEND: begin
          o_cs  <= 1'b1;
          gap_q <= '0;
          if (GAP_CYCLES == 0) begin
            state_q <= SCAN;
            idx_q   <= idx_d;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= SCAN;
            idx_q   <= idx_d;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_info_feeder.sv
// Bench for debug_info_feeder: visuMon-side monitor with an
// expected-write queue, a vector table and refresh/reset sequences.
module tb_debug_info_feeder;
  import debug_info_feeder_pkg::*;

  localparam int N = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              refresh = 1'b0;
  logic [N-1:0]      st;
  logic [N-1:0][3:0] col;
  logic              cs;
  logic              busy;
  debugInfo_t        info;

  debug_info_feeder #(
    .NUM_LEDS   (N),
    .GAP_CYCLES (2)
  ) dut (
    .i_clk25Mhz  (clk),
    .i_reset     (rst_n),
    .i_status    (st),
    .i_color     (col),
    .i_refresh   (refresh),
    .o_cs        (cs),
    .o_debugInfo (info),
    .o_busy      (busy)
  );

  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobes = 0;
  bit chk_en = 1'b0;
  debugInfo_t exp_q[$];
  int stamps[$];
  int hits[N+1];
  debugInfo_t arr[N];

  typedef struct {
    int         sidx;
    logic       sval;
    int         cidx;
    logic [3:0] cval;
    debugInfo_t exp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int s, input logic sv, input int c,
                              input logic [3:0] cv, input logic [7:0] l,
                              input logic [3:0] ec, input logic es);
    vec_t v;
    v.sidx = s;
    v.sval = sv;
    v.cidx = c;
    v.cval = cv;
    v.exp.ledNo = l;
    v.exp.color = ec;
    v.exp.status = es;
    return v;
  endfunction

  always @(posedge clk) cyc++;

  // visuMon side: capture every strobe and score it.
  always @(negedge clk) begin
    if (rst_n && !cs) begin
      strobes++;
      stamps.push_back(cyc);
      if (info.ledNo >= 1 && info.ledNo <= N) begin
        hits[info.ledNo]++;
        arr[info.ledNo-1] = info;
      end
      if (chk_en) begin
        chk("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          chk("strobe_data", 32'(info), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_idle(input int max, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy && cs) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_strobe(input int max, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!cs) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic push_all();
    debugInfo_t e;
    for (int k = 0; k < N; k++) begin
      e.ledNo = 8'(k + 1);
      e.color = col[k];
      e.status = st[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic clr_hits();
    for (int k = 0; k <= N; k++) hits[k] = 0;
  endtask

  function automatic int ones();
    int c = 0;
    for (int k = 1; k <= N; k++) if (hits[k] == 1) c++;
    return c;
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int busy_hi;

    vt[0] = mk(19, 1'b1, -1, 4'h0, 8'd20, 4'hF, 1'b1);
    vt[1] = mk(-1, 1'b0,  4, 4'h3, 8'd5,  4'h3, 1'b0);
    vt[2] = mk( 0, 1'b1, -1, 4'h0, 8'd1,  4'hF, 1'b1);
    vt[3] = mk(-1, 1'b0, 31, 4'h0, 8'd32, 4'h0, 1'b0);
    vt[4] = mk(19, 1'b0, -1, 4'h0, 8'd20, 4'hF, 1'b0);
    vt[5] = mk(-1, 1'b0,  4, 4'hF, 8'd5,  4'hF, 1'b0);

    st = '0;
    for (int k = 0; k < N; k++) col[k] = 4'hF;
    clr_hits();
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_info", 32'(info), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Power-up pass: every LED once, in order, 4 cycles apart.
    push_all();
    chk_en = 1'b1;
    strobes = 0;
    stamps.delete();
    rst_n = 1'b1;
    wait_idle(N * 4 + 20, "pass1_idle");
    repeat (10) @(negedge clk);
    chk("pass1_count", 32'(strobes), 32'd32);
    chk("pass1_queue", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < stamps.size(); i++)
      chk("pass1_spacing", 32'(stamps[i] - stamps[i-1]), 32'd4);
    chk("idle_cs", 32'(cs), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single-LED changes from the table.
    foreach (vt[i]) begin
      @(negedge clk);
      if (vt[i].sidx >= 0) st[vt[i].sidx] = vt[i].sval;
      if (vt[i].cidx >= 0) col[vt[i].cidx] = vt[i].cval;
      exp_q.push_back(vt[i].exp);
      base = strobes;
      wait_idle(N * 4 + 20, $sformatf("vec%0d_idle", i));
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d_count", i), 32'(strobes - base), 32'd1);
      chk($sformatf("vec%0d_queue", i), 32'(exp_q.size()), 32'd0);
    end

    // Short glitch on LED 4 while the pointer sits on index 20.
    @(negedge clk);
    st[19] = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 8'd20, 4'hF, 1'b1).exp);
    wait_strobe(N * 4 + 10, "glitch_sync");
    repeat (3) @(negedge clk);
    st[3] = 1'b1;
    @(negedge clk);
    st[3] = 1'b0;
    base = strobes;
    busy_hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    chk("glitch_busy", 32'(busy_hi), 32'd0);
    chk("glitch_count", 32'(strobes - base), 32'd0);
    chk("glitch_queue", 32'(exp_q.size()), 32'd0);

    // Refresh from idle: one full pass.
    chk_en = 1'b0;
    @(negedge clk);
    clr_hits();
    base = strobes;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_idle(N * 4 + 40, "ref1_idle");
    repeat (10) @(negedge clk);
    chk("ref1_count", 32'(strobes - base), 32'd32);
    chk("ref1_each_once", 32'(ones()), 32'd32);

    // Refresh landing in the SEND of LED 11: that LED is written twice.
    clr_hits();
    base = strobes;
    st[10] = 1'b1;
    wait_strobe(N * 4 + 10, "ref2_sync");
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_idle(N * 4 + 60, "ref2_idle");
    repeat (10) @(negedge clk);
    chk("ref2_count", 32'(strobes - base), 32'd33);
    chk("ref2_led11", 32'(hits[11]), 32'd2);
    chk("ref2_others", 32'(ones()), 32'd31);

    // Reset in the middle of a SEND.
    @(negedge clk);
    col[7] = 4'h5;
    wait_strobe(N * 4 + 10, "rst_sync");
    #3 rst_n = 1'b0;
    #1;
    chk("async_cs", 32'(cs), 32'd1);
    chk("async_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_all();
    base = strobes;
    chk_en = 1'b1;
    rst_n = 1'b1;
    wait_idle(N * 4 + 20, "rst_idle");
    repeat (10) @(negedge clk);
    chk("rst_count", 32'(strobes - base), 32'd32);
    chk("rst_queue", 32'(exp_q.size()), 32'd0);
    chk("arr19", 32'(arr[19]), 32'({8'd20, 4'hF, 1'b1}));
    chk("arr7", 32'(arr[7]), 32'({8'd8, 4'h5, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
